// File: rtl/mac_out_packer.sv
// mac_out_packer: rounds, shifts and saturates 32b MAC results to int8
// and packs four of them little-endian per 32b output word.
//
// Ports:
//   clk_i, rst_i, clear_i       clock, sync reset, sync soft clear
//   start_i, shift_i, len_i     job start pulse and its parameters
//   d_valid_i/d_ready_o/d_data_i/d_strb_i  input result stream
//   q_valid_o/q_ready_i/q_data_o/q_strb_o  packed int8 output stream
//   busy_o, done_o, sat_cnt_o   job status and saturation count
module mac_out_packer #(
  parameter int CNT_WIDTH    = 16,
  parameter int SATCNT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [4:0]              shift_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic                    d_valid_i,
  output logic                    d_ready_o,
  input  logic [31:0]             d_data_i,
  input  logic [3:0]              d_strb_i,
  output logic                    q_valid_o,
  input  logic                    q_ready_i,
  output logic [31:0]             q_data_o,
  output logic [3:0]              q_strb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [SATCNT_WIDTH-1:0] sat_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [4:0]              shift_q;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [1:0]              lane_q;
  logic [31:0]             pack_q;
  logic                    q_valid_q;
  logic [31:0]             q_data_q;
  logic [3:0]              q_strb_q;
  logic                    done_q, done_d;
  logic [SATCNT_WIDTH-1:0] sat_cnt_q;

  logic                    soft_rst;
  logic                    acc;
  logic                    q_hs;
  logic                    last;
  logic                    word_done;
  logic                    launch;

  logic signed [32:0]      xe;
  logic signed [32:0]      rnd;
  logic signed [32:0]      sum;
  logic signed [32:0]      sh;
  logic                    sat_hi, sat_lo;
  logic [7:0]              y;
  logic [31:0]             pack_next;
  logic [3:0]              strb_next;

  logic unused_strb;
  assign unused_strb = ^d_strb_i;

  assign soft_rst  = rst_i | clear_i;
  assign d_ready_o = (state_q == RUN) &&
                     (!q_valid_q || q_ready_i);
  assign acc       = d_valid_i & d_ready_o;
  assign q_hs      = q_valid_q & q_ready_i;
  assign last      = (cnt_q == len_q - 1'b1);
  assign word_done = acc & ((lane_q == 2'd3) | last);
  assign launch    = (state_q == IDLE) & start_i &
                     (len_i != '0);

  // 33b keeps the rounding add from overflowing.
  always_comb begin
    xe  = {d_data_i[31], d_data_i};
    rnd = '0;
    if (shift_q != 5'd0)
      rnd = 33'sd1 <<< (shift_q - 5'd1);
    sum    = xe + rnd;
    sh     = sum >>> shift_q;
    sat_hi = sh > 33'sd127;
    sat_lo = sh < -33'sd128;
    y      = sh[7:0];
    if (sat_hi) y = 8'h7f;
    if (sat_lo) y = 8'h80;
  end

  always_comb begin
    pack_next = pack_q |
                ({24'b0, y} << {lane_q, 3'b000});
    strb_next = 4'b0001;
    unique case (lane_q)
      2'd0: strb_next = 4'b0001;
      2'd1: strb_next = 4'b0011;
      2'd2: strb_next = 4'b0111;
      2'd3: strb_next = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = RUN;
          else             done_d  = 1'b1;
        end
      end
      RUN: begin
        if (acc && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (q_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      shift_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      q_valid_q <= 1'b0;
      q_data_q  <= '0;
      q_strb_q  <= '0;
      sat_cnt_q <= '0;
    end else begin
      if (launch) begin
        shift_q   <= shift_i;
        len_q     <= len_i;
        cnt_q     <= '0;
        lane_q    <= '0;
        pack_q    <= '0;
        sat_cnt_q <= '0;
      end
      if (q_hs) q_valid_q <= 1'b0;
      if (acc) begin
        cnt_q <= cnt_q + 1'b1;
        if ((sat_hi || sat_lo) && (sat_cnt_q != '1))
          sat_cnt_q <= sat_cnt_q + 1'b1;
        if (word_done) begin
          q_valid_q <= 1'b1;
          q_data_q  <= pack_next;
          q_strb_q  <= strb_next;
          pack_q    <= '0;
          lane_q    <= '0;
        end else begin
          pack_q <= pack_next;
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  assign q_valid_o = q_valid_q;
  assign q_data_o  = q_data_q;
  assign q_strb_o  = q_strb_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: doc/mac_out_packer.md
Name: mac_out_packer

Overview:
- Stream stage directly downstream of the MAC engine; consumes its 32b signed result stream.
- Each result gets an arithmetic right shift with round-half-up, then saturation to signed 8b.
- Four consecutive results are packed little-endian into one 32b word on the output stream, which feeds the store streamer.
- A job of LEN results is started by a pulse; the final partial word is flushed with a reduced strobe.

Parameters:
- CNT_WIDTH, 16, width of the job length and element counter.
- SATCNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  one-cycle pulse; latches shift_i and len_i and starts a job.
- shift_i  in  5  right-shift amount, 0..31.
- len_i  in  CNT_WIDTH  number of results in the job.
- d_i  sink  hwpe_stream_intf_stream, DATA_WIDTH=32  MAC results.
  - d_i.strb is ignored.
- q_o  source  hwpe_stream_intf_stream, DATA_WIDTH=32  packed int8 output.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- sat_cnt_o  out  SATCNT_WIDTH  number of saturated elements in the current or last job.

Behaviour:
- Reset / clear values:
  - State IDLE; q_o.valid=0, q_o.data=0, q_o.strb=0.
  - d_i.ready=0, busy_o=0, done_o=0, sat_cnt_o=0.
  - Lane index and element counter = 0.
- Reset or clear mid-job aborts the job immediately. No done_o pulse. Any held output word is dropped.
- States:
  - IDLE:
    - start_i with len_i>0: latch shift/len, zero sat_cnt_o, lane=0, cnt=0, go to RUN.
    - start_i with len_i=0: done_o=1 next cycle, no output word, stay IDLE.
  - RUN:
    - d_i.ready = !q_o.valid || q_o.ready. Input may be accepted in the same cycle the previous word handshakes.
    - On each d_i handshake:
      - y = sat8((x + R) >>> s), computed in 33b signed; R = 0 if s=0, else 1<<(s-1).
      - sat8 clamps to [-128,127]. Each clamp increments sat_cnt_o, which saturates at its maximum and does not wrap.
      - Write y into byte lane `lane` of the packing register; lane++, cnt++.
    - Word completion: lane==3, or the element is the last (cnt==len-1).
    - Next cycle after completion: q_o.valid=1 with the packed word; q_o.strb = one bit per filled lane (0xF, 0x7, 0x3 or 0x1); unfilled bytes = 0; lane resets to 0.
    - Packing register clears after the word is loaded.
    - After the last element is accepted, d_i.ready=0; go to DRAIN.
  - DRAIN:
    - Hold q_o until handshake.
    - On the final q_o handshake: done_o=1 for the next cycle, busy_o drops in that same cycle, return to IDLE.
- Output rules:
  - Latency: 1 cycle from accepting the completing element to q_o.valid.
  - q_o.data and q_o.strb are stable while q_o.valid && !q_o.ready.
  - q_o.valid never deasserts without a handshake, except on reset or clear.
- busy_o=1 in RUN and DRAIN.
- start_i while busy_o=1 is ignored.
- Simultaneous start_i and clear_i: clear wins.
- Full throughput: one element per cycle with q_o.ready held high.

Test Plan:
- Basic pack: shift=0, len=4, inputs 1,2,3,-1 → one word 0xFF030201, strb 0xF; done_o pulses one cycle after the handshake; sat_cnt_o=0.
- Rounding and saturation: shift=4, len=4, inputs 24, -24, 0x7FFFFFFF, -5000 → bytes 0x02, 0xFF, 0x7F, 0x80 (data 0x807FFF02); sat_cnt_o=2.
- Partial flush: shift=0, len=5, inputs 1..5 → word 0x04030201 strb 0xF, then 0x00000005 strb 0x1; exactly one done_o pulse.
- Backpressure: len=8, q_o.ready low for 3 cycles when the first word is valid.
  - d_i.ready=0 during the stall; word stays stable.
  - With continuous input, 8 elements complete in 8+3 cycles plus drain.
- Zero length and busy start: start_i with len=0 → done_o next cycle, q_o.valid never asserts. start_i during RUN → latched params unchanged, output unchanged.
- Mid-job reset: rst_i asserted after 2 of 4 elements → next cycle all outputs at reset values, no done_o. A new job afterwards packs correctly from lane 0.
